frame_slot_mgr: RTL and testbench



---
 rtl/frame_slot_mgr.sv | 216 +++++++++++++++++++++
 tb/tb_frame_slot_mgr.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_slot_mgr.sv
// frame_slot_mgr: frame-slot allocator for the DDR frame buffer.
// One writer and READERS_AMOUNT readers share FRAMES_AMOUNT slots. Slots are
// held by reference count, readers always take the most recently completed
// frame, and a per-reader frame tag drives rd_new_o.
// Optional: FRAME_SLOT_MGR_STATS_EN enables the drop/repeat counters.
module frame_slot_mgr #(
  parameter longint unsigned START_ADDR     = 0,
  parameter int              FRAMES_AMOUNT  = 3,
  parameter longint unsigned FRAME_SIZE_B   = 4147200,
  parameter int              ADDR_WIDTH     = 32,
  parameter int              READERS_AMOUNT = 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n_i,
  input  logic                                 wr_start_i,
  input  logic                                 wr_done_stb_i,
  output logic                                 wr_grant_o,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o,
  input  logic [READERS_AMOUNT-1:0]            rd_start_i,
  input  logic [READERS_AMOUNT-1:0]            rd_done_stb_i,
  output logic [READERS_AMOUNT-1:0]            rd_valid_o,
  output logic [READERS_AMOUNT-1:0]            rd_new_o,
  output logic [READERS_AMOUNT*ADDR_WIDTH-1:0] rd_addr_o,
  output logic [15:0]                          drop_cnt_o,
  output logic [15:0]                          repeat_cnt_o
);
  localparam int F  = FRAMES_AMOUNT;
  localparam int R  = READERS_AMOUNT;
  localparam int AW = ADDR_WIDTH;
  localparam int IW = (F > 1) ? $clog2(F) : 1;
  localparam int CW = $clog2(R + 1);

  if (F < R + 2) begin : g_chk_frames
    $error("frame_slot_mgr: FRAMES_AMOUNT must be >= READERS_AMOUNT + 2");
  end
  if (R < 1 || R > 8) begin : g_chk_readers
    $error("frame_slot_mgr: READERS_AMOUNT must be 1..8");
  end

  function automatic logic [AW-1:0] slot_addr(input logic [IW-1:0] idx);
    return AW'(START_ADDR) + AW'(idx) * AW'(FRAME_SIZE_B);
  endfunction

  logic [F-1:0]           writing_q, writing_d;
  logic [F-1:0][CW-1:0]   refcnt_q, refcnt_d;
  logic [IW-1:0]          latest_idx_q, latest_idx_d;
  logic                   latest_vld_q, latest_vld_d;
  logic                   wr_grant_q, wr_grant_d;
  logic [IW-1:0]          wr_idx_q, wr_idx_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [R-1:0]           rd_valid_q, rd_valid_d;
  logic [R-1:0]           rd_new_q, rd_new_d;
  logic [R-1:0][IW-1:0]   rd_idx_q, rd_idx_d;
  logic [R-1:0][AW-1:0]   rd_addr_q, rd_addr_d;
  // Frame tag: slot of the reader's last frame, dropped when that slot is
  // handed back to the writer so a rewritten slot always reads as new.
  logic [R-1:0]           tag_vld_q, tag_vld_d;
  logic [R-1:0][IW-1:0]   tag_idx_q, tag_idx_d;

  logic [F-1:0]  free;
  logic [IW-1:0] free_idx;
  logic          wr_acc, wr_fin;
  logic [R-1:0]  rd_acc, rd_rel, rd_is_new;

  assign wr_acc = wr_start_i && !wr_grant_q;
  assign wr_fin = wr_done_stb_i && wr_grant_q;
  assign rd_acc = rd_start_i & ~rd_valid_q & {R{latest_vld_q}};
  assign rd_rel = rd_done_stb_i & rd_valid_q;

  // Free-slot search: lowest index not written, not held, not latest
  always_comb begin
    free     = '0;
    free_idx = '0;
    for (int s = 0; s < F; s++)
      free[s] = !writing_q[s] && (refcnt_q[s] == '0) &&
                !(latest_vld_q && (latest_idx_q == IW'(s)));
    for (int s = F - 1; s >= 0; s--)
      if (free[s]) free_idx = IW'(s);
  end

  // Per-reader: does the current latest frame differ from its last frame
  always_comb begin
    rd_is_new = '0;
    for (int r = 0; r < R; r++)
      rd_is_new[r] = !tag_vld_q[r] || (tag_idx_q[r] != latest_idx_q);
  end

  // Slot, writer and reader next state
  always_comb begin
    writing_d    = writing_q;
    refcnt_d     = refcnt_q;
    latest_idx_d = latest_idx_q;
    latest_vld_d = latest_vld_q;
    wr_grant_d   = wr_grant_q;
    wr_idx_d     = wr_idx_q;
    wr_addr_d    = wr_addr_q;
    rd_valid_d   = rd_valid_q;
    rd_new_d     = rd_new_q;
    rd_idx_d     = rd_idx_q;
    rd_addr_d    = rd_addr_q;
    tag_vld_d    = tag_vld_q;
    tag_idx_d    = tag_idx_q;
    if (wr_acc) begin
      writing_d[free_idx] = 1'b1;
      wr_grant_d          = 1'b1;
      wr_idx_d            = free_idx;
      wr_addr_d           = slot_addr(free_idx);
      for (int r = 0; r < R; r++)
        if (tag_idx_q[r] == free_idx) tag_vld_d[r] = 1'b0;
    end
    if (wr_fin) begin
      writing_d[wr_idx_q] = 1'b0;
      wr_grant_d          = 1'b0;
      latest_idx_d        = wr_idx_q;
      latest_vld_d        = 1'b1;
    end
    for (int r = 0; r < R; r++) begin
      if (rd_acc[r]) begin
        rd_valid_d[r]          = 1'b1;
        rd_idx_d[r]            = latest_idx_q;
        rd_addr_d[r]           = slot_addr(latest_idx_q);
        rd_new_d[r]            = rd_is_new[r];
        tag_vld_d[r]           = 1'b1;
        tag_idx_d[r]           = latest_idx_q;
        refcnt_d[latest_idx_q] = refcnt_d[latest_idx_q] + CW'(1);
      end
      if (rd_rel[r]) begin
        rd_valid_d[r]          = 1'b0;
        refcnt_d[rd_idx_q[r]]  = refcnt_d[rd_idx_q[r]] - CW'(1);
      end
    end
  end

  // Slot, writer and reader state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      writing_q    <= '0;
      refcnt_q     <= '0;
      latest_idx_q <= '0;
      latest_vld_q <= 1'b0;
      wr_grant_q   <= 1'b0;
      wr_idx_q     <= '0;
      wr_addr_q    <= '0;
      rd_valid_q   <= '0;
      rd_new_q     <= '0;
      rd_idx_q     <= '0;
      rd_addr_q    <= '0;
      tag_vld_q    <= '0;
      tag_idx_q    <= '0;
    end else begin
      writing_q    <= writing_d;
      refcnt_q     <= refcnt_d;
      latest_idx_q <= latest_idx_d;
      latest_vld_q <= latest_vld_d;
      wr_grant_q   <= wr_grant_d;
      wr_idx_q     <= wr_idx_d;
      wr_addr_q    <= wr_addr_d;
      rd_valid_q   <= rd_valid_d;
      rd_new_q     <= rd_new_d;
      rd_idx_q     <= rd_idx_d;
      rd_addr_q    <= rd_addr_d;
      tag_vld_q    <= tag_vld_d;
      tag_idx_q    <= tag_idx_d;
    end
  end

  assign wr_grant_o = wr_grant_q;
  assign wr_addr_o  = wr_addr_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_new_o   = rd_new_q;
  assign rd_addr_o  = rd_addr_q;

`ifdef FRAME_SLOT_MGR_STATS_EN
  logic [F-1:0] unread_q, unread_d;
  logic [15:0]  drop_q, drop_d, rep_q, rep_d;
  logic [16:0]  rep_sum;
  logic [3:0]   nrep;

  // Statistics: a latest frame replaced without any reader taking it is a
  // drop; a read of the same frame as last time is a repeat
  always_comb begin
    unread_d = unread_q;
    drop_d   = drop_q;
    nrep     = '0;
    for (int r = 0; r < R; r++)
      if (rd_acc[r] && !rd_is_new[r]) nrep = nrep + 4'd1;
    rep_sum = {1'b0, rep_q} + 17'(nrep);
    rep_d   = rep_sum[16] ? 16'hFFFF : rep_sum[15:0];
    if (|rd_acc) unread_d[latest_idx_q] = 1'b0;
    if (wr_fin) begin
      if (latest_vld_q && unread_q[latest_idx_q] && !(|rd_acc) && (drop_q != 16'hFFFF))
        drop_d = drop_q + 16'd1;
      unread_d[wr_idx_q] = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      unread_q <= '0;
      drop_q   <= '0;
      rep_q    <= '0;
    end else begin
      unread_q <= unread_d;
      drop_q   <= drop_d;
      rep_q    <= rep_d;
    end
  end

  assign drop_cnt_o   = drop_q;
  assign repeat_cnt_o = rep_q;
`else
  assign drop_cnt_o   = 16'd0;
  assign repeat_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_frame_slot_mgr.sv
// tb_frame_slot_mgr: directed plus random stimulus for frame_slot_mgr,
// checked against a frame-sequence reference model.
module tb_frame_slot_mgr;
  localparam int          F  = 4;
  localparam int          R  = 2;
  localparam logic [31:0] SA = 32'h1000_0000;
  localparam logic [31:0] FS = 32'd4147200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0, wr_done = 1'b0;
  logic [R-1:0]  rd_start = '0, rd_done = '0;
  logic          wr_grant;
  logic [31:0]   wr_addr;
  logic [R-1:0]  rd_valid, rd_new;
  logic [R*32-1:0] rd_addr;
  logic [15:0]   drop_cnt, repeat_cnt;

  int errors = 0;
  int checks = 0;

  frame_slot_mgr #(
    .START_ADDR(64'h1000_0000), .FRAMES_AMOUNT(F), .FRAME_SIZE_B(64'd4147200),
    .ADDR_WIDTH(32), .READERS_AMOUNT(R)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_start_i(wr_start), .wr_done_stb_i(wr_done),
    .wr_grant_o(wr_grant), .wr_addr_o(wr_addr),
    .rd_start_i(rd_start), .rd_done_stb_i(rd_done),
    .rd_valid_o(rd_valid), .rd_new_o(rd_new), .rd_addr_o(rd_addr),
    .drop_cnt_o(drop_cnt), .repeat_cnt_o(repeat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: frames carry a global sequence number; holders are
  // the writer and each valid reader.
  logic        m_grant;
  int          m_wslot;
  logic [31:0] m_waddr;
  logic        m_lvld;
  int          m_latest;
  logic        m_lread;
  int          m_seq [F];
  int          m_next_seq;
  logic        m_rvalid [R];
  int          m_rslot [R];
  logic        m_rnew [R];
  int          m_rlast [R];
  int          m_drop, m_rep;

  function automatic logic [31:0] addr_of(input int s);
    logic [31:0] a;
    a = SA + 32'(s) * FS;
    return a;
  endfunction

  task automatic model_reset();
    m_grant = 0; m_wslot = 0; m_waddr = '0; m_lvld = 0; m_latest = 0; m_lread = 0;
    m_next_seq = 0; m_drop = 0; m_rep = 0;
    for (int s = 0; s < F; s++) m_seq[s] = -1;
    for (int r = 0; r < R; r++) begin
      m_rvalid[r] = 0; m_rslot[r] = 0; m_rnew[r] = 0; m_rlast[r] = -1;
    end
  endtask

  task automatic model_step(input logic ws, input logic wd, input logic [R-1:0] rs, input logic [R-1:0] rdn);
    logic busy [F];
    int   old_latest, pick, nacc;
    logic old_lvld, old_grant;
    old_latest = m_latest; old_lvld = m_lvld; old_grant = m_grant;
    for (int s = 0; s < F; s++) begin
      busy[s] = (m_grant && m_wslot == s) || (m_lvld && m_latest == s);
      for (int r = 0; r < R; r++) if (m_rvalid[r] && m_rslot[r] == s) busy[s] = 1;
    end
    nacc = 0;
    for (int r = 0; r < R; r++) begin
      if (rs[r] && !m_rvalid[r] && old_lvld) begin
        nacc++;
        m_rvalid[r] = 1;
        m_rslot[r]  = old_latest;
        m_rnew[r]   = (m_rlast[r] != m_seq[old_latest]);
        if (!m_rnew[r] && m_rep < 65535) m_rep++;
        m_rlast[r]  = m_seq[old_latest];
      end else if (rdn[r] && m_rvalid[r]) begin
        m_rvalid[r] = 0;
      end
    end
    if (nacc > 0) m_lread = 1;
    if (ws && !old_grant) begin
      pick = -1;
      for (int s = F - 1; s >= 0; s--) if (!busy[s]) pick = s;
      m_grant = 1; m_wslot = pick; m_waddr = addr_of(pick);
    end else if (wd && old_grant) begin
      if (old_lvld && !m_lread && m_drop < 65535) m_drop++;
      m_grant = 0;
      m_lvld = 1; m_latest = m_wslot; m_lread = 0;
      m_seq[m_wslot] = m_next_seq++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("wr_grant", 32'(wr_grant), 32'(m_grant));
    if (m_grant) check("wr_addr", wr_addr, m_waddr);
    for (int r = 0; r < R; r++) begin
      check($sformatf("rd_valid%0d", r), 32'(rd_valid[r]), 32'(m_rvalid[r]));
      if (m_rvalid[r]) begin
        check($sformatf("rd_addr%0d", r), rd_addr[r*32 +: 32], addr_of(m_rslot[r]));
        check($sformatf("rd_new%0d", r), 32'(rd_new[r]), 32'(m_rnew[r]));
      end
    end
`ifdef FRAME_SLOT_MGR_STATS_EN
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    check("repeat_cnt", 32'(repeat_cnt), 32'(m_rep));
`else
    check("drop_cnt", 32'(drop_cnt), 32'd0);
    check("repeat_cnt", 32'(repeat_cnt), 32'd0);
`endif
  endtask

  task automatic step(input logic ws, input logic wd, input logic [R-1:0] rs, input logic [R-1:0] rdn);
    wr_start = ws; wr_done = wd; rd_start = rs; rd_done = rdn;
    @(posedge clk);
    model_step(ws, wd, rs, rdn);
    #1;
    wr_start = 0; wr_done = 0; rd_start = '0; rd_done = '0;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 32'(wr_grant), 32'd0);
    check({tag, "_waddr"}, wr_addr, 32'd0);
    check({tag, "_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_new"}, 32'(rd_new), 32'd0);
    check({tag, "_raddr"}, rd_addr[31:0] | rd_addr[63:32], 32'd0);
    check({tag, "_cnt"}, {drop_cnt, repeat_cnt}, 32'd0);
  endtask

  initial begin
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Read request with no frame written is ignored
    step(0, 0, 2'b01, 2'b00);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 2'b00, 2'b00);
      check("no_frame_valid", 32'(rd_valid[0]), 32'd0);
    end

    // First grant and first read
    step(1, 0, 2'b00, 2'b00);
    check("first_grant", 32'(wr_grant), 32'd1);
    check("first_waddr", wr_addr, SA);
    step(0, 1, 2'b00, 2'b00);
    step(0, 0, 2'b01, 2'b00);
    check("first_raddr", rd_addr[31:0], SA);
    check("first_rnew", 32'(rd_new[0]), 32'd1);
    step(1, 0, 2'b00, 2'b00);
    check("second_waddr", wr_addr, SA + FS);
    step(0, 1, 2'b00, 2'b00);
    // Slot 1 superseded unread by slot 2
    step(1, 0, 2'b00, 2'b00);
    check("third_waddr", wr_addr, SA + 2 * FS);
    step(0, 1, 2'b00, 2'b00);
`ifdef FRAME_SLOT_MGR_STATS_EN
    check("drop_one", 32'(drop_cnt), 32'd1);
`endif
    step(1, 0, 2'b00, 2'b00);
    check("reuse_slot1", wr_addr, SA + FS);
    step(0, 1, 2'b00, 2'b00);

    // Repeat read of the same frame
    step(0, 0, 2'b00, 2'b01);
    step(0, 0, 2'b01, 2'b00);
    check("fresh_rnew", 32'(rd_new[0]), 32'd1);
    step(0, 0, 2'b00, 2'b01);
    step(0, 0, 2'b01, 2'b00);
    check("repeat_rnew", 32'(rd_new[0]), 32'd0);
    step(0, 0, 2'b00, 2'b01);

    // Done and read in the same cycle: reader takes the old latest
    step(1, 0, 2'b00, 2'b00);
    step(0, 1, 2'b01, 2'b00);
    check("concurrent_old", rd_addr[31:0], SA + FS);
    step(0, 0, 2'b00, 2'b01);
    step(0, 0, 2'b01, 2'b00);
    check("concurrent_next", rd_addr[31:0], SA);
    check("concurrent_new", 32'(rd_new[0]), 32'd1);

    // Reset mid-grant abandons everything
    step(0, 0, 2'b00, 2'b01);
    step(1, 0, 2'b00, 2'b00);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1, 0, 2'b00, 2'b00);
    check("post_reset_slot0", wr_addr, SA);
    step(0, 1, 2'b00, 2'b00);

    // Both readers hold slot 0 while the writer cycles five frames
    step(0, 0, 2'b11, 2'b00);
    check("dual_addr1", rd_addr[63:32], SA);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 2'b00, 2'b00);
      check("slot0_held", 32'(wr_addr != SA), 32'd1);
      step(0, 1, 2'b00, 2'b00);
    end
    step(0, 0, 2'b00, 2'b01);
    step(1, 0, 2'b00, 2'b00);
    check("slot0_held_one", 32'(wr_addr != SA), 32'd1);
    step(0, 1, 2'b00, 2'b00);
    step(0, 0, 2'b00, 2'b10);
    step(1, 0, 2'b00, 2'b00);
    check("slot0_released", wr_addr, SA);
    step(0, 1, 2'b00, 2'b00);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           R'($urandom_range(0, 3) & $urandom_range(0, 3)),
           R'($urandom_range(0, 3) & $urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
